seq_mult: RTL

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/seq_mult_sign_adj.sv | 25 ++
 rtl/seq_mult.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/seq_mult_sign_adj.sv
// Two's complement magnitude extraction and product negation for signed multiplies.
// Instantiated by seq_mult only when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_sign_adj #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               neg,
  input  logic [2*WIDTH-1:0] prod_in,
  input  logic               neg_in,
  output logic [2*WIDTH-1:0] prod_out
);

  // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  always_comb begin
    mag_a    = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b    = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    neg      = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    prod_out = neg_in ? (~prod_in + 1'b1) : prod_in;
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, fixed latency.
// Optional signed operation is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_mult: WIDTH out of legal range");
  end

  state_t              state;
  logic [2*WIDTH:0]    acc;
  logic [2*WIDTH:0]    acc_nxt;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    mcand;
  logic [CntW-1:0]     cnt;
  logic [CntW-1:0]     cnt_nxt;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [2*WIDTH-1:0]  prod_fin;

  // Add into the upper WIDTH+1 bits, then shift the whole accumulator right in the same cycle.
  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
    cnt_nxt = cnt + 1'b1;
  end

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  logic neg_q;

  seq_mult_sign_adj #(
    .WIDTH (WIDTH)
  ) u_sign_adj (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg         (neg),
    .prod_in     (acc_nxt[2*WIDTH-1:0]),
    .neg_in      (neg_q),
    .prod_out    (prod_fin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= neg;
    end
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;
  assign mag_a              = a;
  assign mag_b              = b;
  assign prod_fin           = acc_nxt[2*WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= {{(WIDTH + 1){1'b0}}, mag_a};
            mcand <= mag_b;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          // Final iteration: the product is taken from the post-shift accumulator.
          if (cnt_nxt == CntW'(WIDTH)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= prod_fin;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
